timer_uart_peripheral: RTL and testbench
========================================

Name: timer_uart_peripheral

Overview:
Memory-mapped peripheral block sitting directly downstream of the single-cycle core's data-memory port, alongside data RAM in the top module. Decodes the 0x4000_00xx window and provides a 32-bit reload timer that drives the core's interrupt input, plus an 8N1 UART transmitter. Writes take effect on the clock edge. Reads are combinational, so the core can load within its single cycle.

Parameters:
BAUD_DIV, 10417, clock cycles per UART bit (100 MHz / 9600 baud); legal range 2..65535.
BASE_ADDR, 32'h4000_0000, base of the peripheral window; the offsets below are added to it.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
iAddr  in  32  byte address from the core (its ALU output)
iMemRead  in  1  read strobe
iMemWrite  in  1  write strobe, sampled at rising clk
iWriteData  in  32  store data
oReadData  out  32  combinational read data; top muxes this with RAM
oSelect  out  1  iAddr inside the peripheral window (BASE_ADDR..BASE_ADDR+0x1F); top uses it to steer the read mux and block the RAM write
oInterrupt  out  1  timer interrupt request to the core
oUartTx  out  1  serial output, idle high

Behaviour:
- Register map (word offsets; iAddr[1:0] ignored):
  - 0x00 TH, R/W 32 bits: reload value.
  - 0x04 TL, R/W 32 bits: counter.
  - 0x08 TCON, R/W, bits[2:0]: b0 run, b1 IRQ enable, b2 IRQ status. Bits[31:3] read 0.
  - 0x18 UTXD, W: data in bits[7:0]; reads return the last accepted byte in [7:0].
  - 0x1C USTAT, R: b0 tx busy, b1 tx done (sticky); write 1 to b1 clears it.
  - All other offsets in the window read 0 and ignore writes.
- oReadData = register value when iMemRead && oSelect; otherwise 0. Purely combinational, zero latency.
- Reset values: TH=0, TL=0, TCON=0, UTXD=0, busy=0, done=0, oUartTx=1, oInterrupt=0, UART FSM=IDLE, bit/baud counters=0.
- Timer, evaluated each clk while TCON.b0=1:
  - If TL==32'hFFFF_FFFF: TL<=TH, and if TCON.b1=1 then TCON.b2<=1.
  - Otherwise TL<=TL+1 (modulo 2^32).
  - Period is therefore (2^32 - TH) cycles.
- oInterrupt = TCON.b2 & TCON.b1 (registered bits; no combinational path from the bus).
- Simultaneous timer/CPU events:
  - CPU write to TL in the same cycle as a count or reload: the CPU write wins.
  - CPU write to TCON in the same cycle the hardware sets b2: b0 and b1 take the written value; b2 ends at 1 (hardware set wins over software clear).
  - CPU write to TH takes effect for the next reload, including a reload occurring in the same cycle (old TH used in that cycle).
- Interrupt service: ISR clears b2 by writing TCON with b2=0. oInterrupt falls the cycle after that write edge.
- UART TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: a write to UTXD while busy=0 latches the byte, sets busy, clears done, and moves to START. oUartTx goes 0 at that same edge.
  - A write to UTXD while busy=1 is ignored (byte and FSM unchanged).
  - Each state holds for BAUD_DIV cycles, counted by a baud counter 0..BAUD_DIV-1.
  - DATA sends bits 0..7, LSB first, with a 3-bit index; it moves to STOP after bit 7.
  - STOP drives 1 for BAUD_DIV cycles, then returns to IDLE with busy=0 and done=1.
  - A whole frame is 10*BAUD_DIV cycles from the accepting edge to busy falling.
  - A write to UTXD on the same edge that STOP finishes is ignored (busy still 1 when sampled).
- Reset asserted mid-frame or mid-count: everything returns to reset values immediately; oUartTx goes 1 asynchronously and no partial frame resumes.
- iMemRead and iMemWrite together: the write happens at the edge, and the read shows pre-edge values.

Test Plan:
1. Reset with ports idle -> oUartTx=1, oInterrupt=0, reads of 0x00/0x04/0x08/0x1C all return 0.
2. Write TH=FFFF_FFFC, TL=FFFF_FFFE, TCON=3 -> TL reads FFFF_FFFF one cycle later; the next edge reloads TL=FFFF_FFFC and TCON reads 7; oInterrupt=1; thereafter oInterrupt is re-asserted every 4 cycles unless cleared.
3. With the timer in IRQ, write TCON=3 on a non-overflow cycle -> oInterrupt=0 the next cycle. Repeat the write on the reload cycle -> TCON reads 7 (set wins).
4. BAUD_DIV=4, write UTXD=0xA5 -> oUartTx sequence per 4-cycle slot: 0,1,0,1,0,0,1,0,1,1. USTAT=1 during the frame; USTAT=2 at cycle 40 (10 slots × 4 cycles).
5. Write UTXD=0x55 during a busy frame -> ignored; the frame still carries 0xA5. Then write USTAT=2 -> done cleared, USTAT reads 0.
6. Assert reset at cycle 13 of a frame and with the timer running -> oUartTx=1 and TL=TH=TCON=0 immediately; after release, no further frame bits or interrupts.

Source files
------------

// File: rtl/timer_uart_peripheral.sv
// Memory-mapped timer + 8N1 UART transmitter in the 0x4000_00xx window.
// The register file is written on the rising clock edge. Reads are purely
// combinational so a single-cycle core can complete a load in one cycle.
module timer_uart_peripheral #(
    parameter int unsigned BAUD_DIV  = 10417,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iAddr,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [31:0] iWriteData,
    output logic [31:0] oReadData,
    output logic        oSelect,
    output logic        oInterrupt,
    output logic        oUartTx
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    logic [31:0] offset;
    logic [2:0]  word;
    logic        wr_th, wr_tl, wr_tcon, wr_utxd, wr_ustat;

    logic [31:0] th_reg, tl_reg;
    logic [2:0]  tcon_reg;
    logic        irq_set;

    uart_state_t state_reg;
    logic [15:0] baud_reg;
    logic [2:0]  bit_idx_reg;
    logic [2:0]  bit_idx_next;
    logic [7:0]  utxd_reg;
    logic        tx_reg;
    logic        done_reg;
    logic        busy;
    logic        baud_done;

    // Window decode: subtracting the base first keeps this correct even for
    // a base address that is not aligned to 32 bytes.
    assign offset  = iAddr - BASE_ADDR;
    assign oSelect = (offset[31:5] == 27'd0);
    assign word    = 3'(offset[4:0] >> 2);

    assign wr_th    = iMemWrite && oSelect && (word == 3'd0);
    assign wr_tl    = iMemWrite && oSelect && (word == 3'd1);
    assign wr_tcon  = iMemWrite && oSelect && (word == 3'd2);
    assign wr_utxd  = iMemWrite && oSelect && (word == 3'd6);
    assign wr_ustat = iMemWrite && oSelect && (word == 3'd7);

    // Hardware sets the IRQ status on the overflow cycle only when enabled.
    assign irq_set    = tcon_reg[0] && (tl_reg == ALL_ONES) && tcon_reg[1];
    assign oInterrupt = tcon_reg[2] & tcon_reg[1];

    assign busy         = (state_reg != IDLE);
    assign baud_done    = (baud_reg == BAUD_LAST);
    assign bit_idx_next = bit_idx_reg + 3'd1;
    assign oUartTx      = tx_reg;

    // Reload timer: CPU writes to TL beat counting; a hardware IRQ set beats
    // a software clear of the status bit written in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_reg   <= 32'd0;
            tl_reg   <= 32'd0;
            tcon_reg <= 3'd0;
        end else begin
            if (wr_th)
                th_reg <= iWriteData;
            if (wr_tl)
                tl_reg <= iWriteData;
            else if (tcon_reg[0])
                tl_reg <= (tl_reg == ALL_ONES) ? th_reg : tl_reg + 32'd1;
            if (wr_tcon)
                tcon_reg <= {iWriteData[2] | irq_set, iWriteData[1:0]};
            else if (irq_set)
                tcon_reg[2] <= 1'b1;
        end
    end

    // UART transmit FSM: each state lasts BAUD_DIV cycles; the serial line
    // is a registered output updated on the edge that enters each bit slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            baud_reg    <= 16'd0;
            bit_idx_reg <= 3'd0;
            utxd_reg    <= 8'd0;
            tx_reg      <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            if (wr_ustat && iWriteData[1])
                done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (wr_utxd) begin
                        utxd_reg  <= iWriteData[7:0];
                        done_reg  <= 1'b0;
                        tx_reg    <= 1'b0;
                        baud_reg  <= 16'd0;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_reg    <= 16'd0;
                        bit_idx_reg <= 3'd0;
                        tx_reg      <= utxd_reg[0];
                        state_reg   <= DATA;
                    end else begin
                        baud_reg <= baud_reg + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_reg <= 16'd0;
                        if (bit_idx_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_next;
                            tx_reg      <= utxd_reg[bit_idx_next];
                        end
                    end else begin
                        baud_reg <= baud_reg + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_reg  <= 16'd0;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        baud_reg <= baud_reg + 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Combinational read mux; zero unless this block is being read.
    always_comb begin
        oReadData = 32'd0;
        if (iMemRead && oSelect) begin
            case (word)
                3'd0:    oReadData = th_reg;
                3'd1:    oReadData = tl_reg;
                3'd2:    oReadData = {29'd0, tcon_reg};
                3'd6:    oReadData = {24'd0, utxd_reg};
                3'd7:    oReadData = {30'd0, done_reg, busy};
                default: oReadData = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_uart_peripheral.sv
// Directed bench for timer_uart_peripheral with a short baud divider.
module tb_timer_uart_peripheral;

    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam logic [31:0] A_TH  = BASE + 32'h00;
    localparam logic [31:0] A_TL  = BASE + 32'h04;
    localparam logic [31:0] A_TC  = BASE + 32'h08;
    localparam logic [31:0] A_TX  = BASE + 32'h18;
    localparam logic [31:0] A_ST  = BASE + 32'h1C;

    logic        clk;
    logic        reset;
    logic [31:0] iAddr;
    logic        iMemRead;
    logic        iMemWrite;
    logic [31:0] iWriteData;
    logic [31:0] oReadData;
    logic        oSelect;
    logic        oInterrupt;
    logic        oUartTx;

    int checks;
    int failures;

    // Expected line level per bit slot, slot 0 in bit 0: start, A5 LSB first, stop.
    logic [9:0] exp_tx;

    timer_uart_peripheral #(
        .BAUD_DIV  (4),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .iAddr      (iAddr),
        .iMemRead   (iMemRead),
        .iMemWrite  (iMemWrite),
        .iWriteData (iWriteData),
        .oReadData  (oReadData),
        .oSelect    (oSelect),
        .oInterrupt (oInterrupt),
        .oUartTx    (oUartTx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] addr, input logic [31:0] expv);
        iAddr    = addr;
        iMemRead = 1'b1;
        #1;
        chk(tag, oReadData, expv);
        iMemRead = 1'b0;
    endtask

    // Write on the next rising edge; returns 1 time unit after that edge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        iAddr      = addr;
        iWriteData = data;
        iMemWrite  = 1'b1;
        @(posedge clk);
        #1;
        iMemWrite = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        exp_tx     = 10'b1101001010;
        reset      = 1'b1;
        iAddr      = 32'd0;
        iMemRead   = 1'b0;
        iMemWrite  = 1'b0;
        iWriteData = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1: reset state
        chk("rst_tx", {31'd0, oUartTx}, 32'd1);
        chk("rst_irq", {31'd0, oInterrupt}, 32'd0);
        chk_rd("rst_th", A_TH, 32'd0);
        chk_rd("rst_tl", A_TL, 32'd0);
        chk_rd("rst_tcon", A_TC, 32'd0);
        chk_rd("rst_ustat", A_ST, 32'd0);

        // Read and write together: read shows the pre-edge value
        @(negedge clk);
        iAddr      = A_TH;
        iWriteData = 32'hFFFF_FFFC;
        iMemWrite  = 1'b1;
        iMemRead   = 1'b1;
        #1;
        chk("rw_pre", oReadData, 32'd0);
        @(posedge clk);
        #1;
        chk("rw_post", oReadData, 32'hFFFF_FFFC);
        iMemWrite = 1'b0;
        iMemRead  = 1'b0;

        // Window decode
        iAddr = BASE + 32'h1F;
        #1;
        chk("sel_in", {31'd0, oSelect}, 32'd1);
        iAddr = BASE + 32'h20;
        #1;
        chk("sel_out", {31'd0, oSelect}, 32'd0);
        chk_rd("rd_out", BASE + 32'h20, 32'd0);
        chk_rd("rd_unmapped", BASE + 32'h0C, 32'd0);
        iAddr = A_TH;
        #1;
        chk("rd_nostrobe", oReadData, 32'd0);

        // 2: timer overflow and reload
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TC, 32'd3);
        chk_rd("t_tl0", A_TL, 32'hFFFF_FFFE);
        step();
        chk_rd("t_tl1", A_TL, 32'hFFFF_FFFF);
        chk("t_irq1", {31'd0, oInterrupt}, 32'd0);
        step();
        chk_rd("t_reload", A_TL, 32'hFFFF_FFFC);
        chk_rd("t_tcon7", A_TC, 32'd7);
        chk("t_irq2", {31'd0, oInterrupt}, 32'd1);

        // 3: software clear on a non-overflow cycle, then on the reload cycle
        wr(A_TC, 32'd3);
        chk("clr_irq", {31'd0, oInterrupt}, 32'd0);
        chk_rd("clr_tcon", A_TC, 32'd3);
        chk_rd("clr_tl", A_TL, 32'hFFFF_FFFD);
        step();
        step();
        chk_rd("pre_ovf_tl", A_TL, 32'hFFFF_FFFF);
        chk("pre_ovf_irq", {31'd0, oInterrupt}, 32'd0);
        wr(A_TC, 32'd3);
        chk_rd("setwins_tcon", A_TC, 32'd7);
        chk("setwins_irq", {31'd0, oInterrupt}, 32'd1);
        chk_rd("setwins_tl", A_TL, 32'hFFFF_FFFC);

        // CPU write to TL beats the count
        wr(A_TC, 32'd1);
        chk("run_noie_irq", {31'd0, oInterrupt}, 32'd0);
        wr(A_TL, 32'd5);
        chk_rd("tlwr_wins", A_TL, 32'd5);
        step();
        chk_rd("tl_count", A_TL, 32'd6);
        wr(A_TC, 32'd0);
        step();
        chk_rd("tl_stopped", A_TL, 32'd7);

        // 4 + 5: UART frame of 0xA5, ignored write of 0x55 mid-frame
        wr(A_TX, 32'h0000_00A5);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("tx_slot%0d", k), {31'd0, oUartTx}, {31'd0, exp_tx[k]});
            chk_rd($sformatf("ustat_slot%0d", k), A_ST, 32'd1);
            if (k == 2) begin
                wr(A_TX, 32'h0000_0055);
                repeat (3) @(posedge clk);
                #1;
            end else if (k < 9) begin
                repeat (4) @(posedge clk);
                #1;
            end
        end
        chk_rd("utxd_kept", A_TX, 32'h0000_00A5);
        // Now 36 cycles after acceptance; busy must still hold through cycle 39.
        repeat (3) @(posedge clk);
        #1;
        chk_rd("ustat_c39", A_ST, 32'd1);
        step();
        chk_rd("ustat_c40", A_ST, 32'd2);
        chk("tx_idle", {31'd0, oUartTx}, 32'd1);
        wr(A_ST, 32'd2);
        chk_rd("ustat_clr", A_ST, 32'd0);

        // 6: reset mid-frame with the timer running
        wr(A_TH, 32'h0000_0010);
        wr(A_TL, 32'hFFFF_FFFA);
        wr(A_TC, 32'd3);
        wr(A_TX, 32'h0000_0000);
        repeat (12) @(posedge clk);
        #2;
        chk("pre_rst_tx", {31'd0, oUartTx}, 32'd0);
        chk("pre_rst_irq", {31'd0, oInterrupt}, 32'd1);
        chk_rd("pre_rst_tl", A_TL, 32'h0000_0017);
        reset = 1'b1;
        #1;
        chk("mid_rst_tx", {31'd0, oUartTx}, 32'd1);
        chk("mid_rst_irq", {31'd0, oInterrupt}, 32'd0);
        chk_rd("mid_rst_th", A_TH, 32'd0);
        chk_rd("mid_rst_tl", A_TL, 32'd0);
        chk_rd("mid_rst_tcon", A_TC, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step();
            chk($sformatf("post_rst_tx%0d", c), {31'd0, oUartTx}, 32'd1);
            chk($sformatf("post_rst_irq%0d", c), {31'd0, oInterrupt}, 32'd0);
        end
        chk_rd("post_rst_ustat", A_ST, 32'd0);
        chk_rd("post_rst_tl", A_TL, 32'd0);
        chk_rd("post_rst_utxd", A_TX, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
